// File: rtl/elevator_call_panel.sv
// Button front-end for the two-floor elevator: synchronise, debounce and latch
// hall/cabin presses as calls, clear them once the door has been open at the floor.
module elevator_call_panel #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned SERVE_CYCLES    = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btn0_i,
  input  logic       btn1_i,
  input  logic       open_i,
  input  logic       floor0_i,
  input  logic       floor1_i,
  output logic       call0_o,
  output logic       call1_o,
  output logic       lamp0_o,
  output logic       lamp1_o,
  output logic [7:0] served_cnt_o,
  output logic       stuck_o
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(SERVE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, PENDING, SERVING} state_e;

  logic [1:0] btn;
  logic [1:0] at_floor;
  logic [1:0] here;
  logic [1:0] done;
  logic [1:0] age_hit;
  logic [1:0] call;
  logic [1:0] lamp;

  assign btn      = {btn1_i, btn0_i};
  assign at_floor = {floor1_i, floor0_i};

  for (genvar g = 0; g < 2; g++) begin : g_floor
    logic          sync1_q, sync2_q;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    state_e        state_q, state_d;
    logic [SW-1:0] srv_q, srv_d;
    logic [15:0]   age_q, age_d;
    logic          call_q, lamp_q;
    logic          done_l;

    // Both floor sensors high is treated as "nowhere", so no call can clear.
    assign here[g] = at_floor[g] & open_i & ~(floor0_i & floor1_i);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
      cnt_d   = '0;
      press_d = 1'b0;
      if (sync2_q) begin
        cnt_d   = (cnt_q == DW'(DEBOUNCE_CYCLES)) ? cnt_q : cnt_q + 1'b1;
        press_d = (cnt_q == DW'(DEBOUNCE_CYCLES - 1));
      end
    end

    always_comb begin
      state_d = state_q;
      srv_d   = srv_q;
      done_l  = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (press_q) state_d = PENDING;
        end
        PENDING: begin
          if (here[g]) begin
            state_d = SERVING;
            srv_d   = SW'(1);
          end
        end
        SERVING: begin
          // A fresh press while serving restarts the hold so the door stays open.
          if (press_q) begin
            srv_d = SW'(1);
          end else if (!here[g]) begin
            state_d = PENDING;
            srv_d   = '0;
          end else if (int'(srv_q) + 1 >= int'(SERVE_CYCLES)) begin
            state_d = IDLE;
            srv_d   = '0;
            done_l  = 1'b1;
          end else begin
            srv_d = srv_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    always_comb begin
      age_d = '0;
      if (state_q == PENDING && state_d == PENDING) begin
        age_d = (age_q == 16'(TIMEOUT_CYCLES)) ? age_q : age_q + 16'd1;
      end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        cnt_q   <= '0;
        press_q <= 1'b0;
        state_q <= IDLE;
        srv_q   <= '0;
        age_q   <= '0;
        call_q  <= 1'b0;
        lamp_q  <= 1'b0;
      end else begin
        sync1_q <= btn[g];
        sync2_q <= sync1_q;
        cnt_q   <= cnt_d;
        press_q <= press_d;
        state_q <= state_d;
        srv_q   <= srv_d;
        age_q   <= age_d;
        call_q  <= (state_d != IDLE);
        lamp_q  <= (state_d == PENDING);
      end
    end

    assign done[g]    = done_l;
    assign age_hit[g] = (age_d == 16'(TIMEOUT_CYCLES));
    assign call[g]    = call_q;
    assign lamp[g]    = lamp_q;
  end

  logic [7:0] served_q, served_d;
  logic       stuck_q;

  assign served_d = served_q + 8'(done[0]) + 8'(done[1]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      served_q <= '0;
      stuck_q  <= 1'b0;
    end else begin
      served_q <= served_d;
      stuck_q  <= |age_hit;
    end
  end

  assign call0_o      = call[0];
  assign call1_o      = call[1];
  assign lamp0_o      = lamp[0];
  assign lamp1_o      = lamp[1];
  assign served_cnt_o = served_q;
  assign stuck_o      = stuck_q;

endmodule
